div_stall_unit: RTL and testbench
=================================

DIV_STALL_UNIT -- requirements
Module: div_stall_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  EX requests a divide; held high by EX while the pipeline stalls.
REQ-004 SHALL have port signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 SHALL have port dividend  input  32  operand A.
REQ-006 SHALL have port divisor  input  32  operand B.
REQ-007 SHALL have port annul  input  1  cancel the in-flight divide (flush).
REQ-008 SHALL have port stallreq  output  1  stall request to the pipeline controller; uses the Stop encoding (1 = Stop).
REQ-009 SHALL have port ready  output  1  result valid this cycle.
REQ-010 SHALL have port quot  output  32  quotient (LO).
REQ-011 SHALL have port rem  output  32  remainder (HI).

Function
REQ-012 SHALL implement an FSM with states IDLE, ON, DIVZERO and END.
REQ-013 IDLE with start=1 and divisor!=0 SHALL latch the operands and move to ON.
REQ-014 IDLE with start=1 and divisor==0 SHALL move to DIVZERO.
REQ-015 DIVZERO SHALL last 1 cycle and then move to END with quot=0 and rem=0.
REQ-016 ON SHALL perform radix-2 restoring shift-subtract, 1 bit per cycle, for exactly 32 cycles using a 6-bit counter, then move to END.
REQ-017 END SHALL last 1 cycle with ready=1 and results valid, then move to IDLE unconditionally.
REQ-018 stallreq SHALL be combinational: 1 when (IDLE and start=1) or state is ON or DIVZERO; 0 in END and otherwise.
REQ-019 Latency: with start in IDLE at cycle 0, ready SHALL be 1 at cycle 33 for a nonzero divisor and at cycle 2 for divisor 0; stallreq SHALL be 1 in cycles 0..32 (resp. 0..1).
REQ-020 Signed mode SHALL divide operand magnitudes and then negate the quotient if the operand signs differ.
REQ-021 In signed mode the remainder SHALL take the sign of the dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quot=0x80000000 and rem=0 (wrap, no trap).
REQ-023 Outside END, quot, rem and ready SHALL be 0.
REQ-024 annul=1 in any state SHALL force IDLE on the next edge.
REQ-025 annul=1 SHALL force stallreq=0 and ready=0 combinationally in the same cycle and SHALL take priority over start.
REQ-026 Operand changes after the latch cycle SHALL NOT affect the result.
REQ-027 A start present in IDLE in the cycle after END SHALL begin a new divide.

Reset
REQ-028 rst=1 SHALL force state IDLE, counter 0, and the internal dividend and remainder registers to 0 on the next edge, including mid-divide.
REQ-029 While rst=1, stallreq, ready, quot and rem SHALL be 0.
REQ-030 rst SHALL take priority over annul and start.

Structure
REQ-031 The state encodings, the StallBus width (6), Stop/NoStop and DivResultReady/NotReady constants SHALL live in the shared defines package.
REQ-032 The block SHALL be a single module; the 33-bit subtract-compare step MAY be one sub-module, div_step.
REQ-033 stallreq SHALL feed the controller's EX stall-request input directly, with no register in between.

Verification
REQ-034 Unsigned 100/7, start held -> stallreq=1 in cycles 0..32; ready at cycle 33 with quot=14, rem=2.
REQ-035 Signed -7/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF at cycle 33.
REQ-036 5/0 -> stallreq=1 in cycles 0..1; ready at cycle 2 with quot=0, rem=0.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-038 annul at cycle 10 -> stallreq=0 at cycle 10, state IDLE at cycle 11, no ready pulse; a new start at cycle 12 computes correctly.
REQ-039 rst at cycle 20 mid-divide -> all outputs 0 from cycle 21; unsigned 0xFFFFFFFF/1 afterward -> quot=0xFFFFFFFF, rem=0.

Source files
------------

// File: rtl/div_stall_unit_pkg.sv
// Shared defines for the multi-cycle divider: state encodings, stall-bus
// constants and an operand-magnitude helper.
package div_stall_unit_pkg;

    localparam int unsigned StallBusW = 6;
    localparam int unsigned DivW      = 32;

    localparam logic Stop              = 1'b1;
    localparam logic NoStop            = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_ON      = 2'b01,
        DIV_DIVZERO = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement magnitude when signed and negative; 0x80000000 maps to itself.
    function automatic logic [DivW-1:0] mag(input logic is_signed, input logic [DivW-1:0] v);
        return (is_signed && v[DivW-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_stall_unit_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder, subtracts the divisor if it fits, and yields one quotient bit.
module div_step
    import div_stall_unit_pkg::*;
(
    input  logic [DivW-1:0] rem_i,
    input  logic            bit_i,
    input  logic [DivW-1:0] divisor_i,
    output logic [DivW-1:0] rem_o,
    output logic            q_o
);

    logic [DivW-1:0] low;

    // The 33-bit partial is {rem_i[31], low}; a set top bit always exceeds the
    // divisor, and the true difference then fits in 32 bits, so wrap is exact.
    assign low   = {rem_i[DivW-2:0], bit_i};
    assign q_o   = rem_i[DivW-1] | (low >= divisor_i);
    assign rem_o = q_o ? (low - divisor_i) : low;

endmodule

// File: rtl/div_stall_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit that stalls the pipeline while it iterates
// and presents quotient/remainder for a single END cycle.
module div_stall_unit
    import div_stall_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_div,
    input  logic [DivW-1:0] dividend,
    input  logic [DivW-1:0] divisor,
    input  logic            annul,
    output logic            stallreq,
    output logic            ready,
    output logic [DivW-1:0] quot,
    output logic [DivW-1:0] rem
);

    div_state_e      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [DivW-1:0] dvd_q, dvd_d;
    logic [DivW-1:0] rem_q, rem_d;
    logic [DivW-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic [DivW-1:0] step_rem;
    logic            step_q;

    div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DivW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        stallreq = NoStop;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    stallreq = Stop;
                    cnt_d    = '0;
                    rem_d    = '0;
                    if (divisor != '0) begin
                        state_d = DIV_ON;
                        dvd_d   = mag(signed_div, dividend);
                        dvs_d   = mag(signed_div, divisor);
                        qneg_d  = signed_div & (dividend[DivW-1] ^ divisor[DivW-1]);
                        rneg_d  = signed_div & dividend[DivW-1];
                    end else begin
                        state_d = DIV_DIVZERO;
                        dvd_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end
                end
            end
            DIV_ON: begin
                stallreq = Stop;
                // Dividend register doubles as the quotient shift register.
                dvd_d    = {dvd_q[DivW-2:0], step_q};
                rem_d    = step_rem;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DIV_END;
                end
            end
            DIV_DIVZERO: begin
                stallreq = Stop;
                state_d  = DIV_END;
            end
            DIV_END: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (annul || rst) begin
            state_d  = DIV_IDLE;
            stallreq = NoStop;
        end
    end

    assign ready = (!rst && !annul && state_q == DIV_END) ? DivResultReady : DivResultNotReady;
    assign quot  = ready ? (qneg_q ? (~dvd_q + 1'b1) : dvd_q) : '0;
    assign rem   = ready ? (rneg_q ? (~rem_q + 1'b1) : rem_q) : '0;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed self-checking bench for div_stall_unit: latency, stall window,
// signed/unsigned results, divide-by-zero, annul and mid-divide reset.
module tb_div_stall_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq;
    logic        ready;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks;
    int errors;

    div_stall_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stallreq   (stallreq),
        .ready      (ready),
        .quot       (quot),
        .rem        (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
    task automatic run_divide(input logic sg, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] eq, input logic [31:0] er, input string nm);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1; signed_div = sg; dividend = a; divisor = b;
            end else if (c < lat) begin
                start = 1'b1; signed_div = ~sg;
                dividend = a ^ 32'h5A5A_A5A5; divisor = b + 32'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (stallreq !== ((c < lat) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s stallreq cyc %0d got %b want %b", nm, c, stallreq, (c < lat));
            end
            checks++;
            if (ready !== ((c == lat) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s ready cyc %0d got %b want %b", nm, c, ready, (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (quot !== eq || rem !== er) begin
                    errors++;
                    $display("FAIL %s result got q=%h r=%h want q=%h r=%h", nm, quot, rem, eq, er);
                end
            end else begin
                checks++;
                if (quot !== 32'd0 || rem !== 32'd0) begin
                    errors++;
                    $display("FAIL %s idle_outputs cyc %0d got q=%h r=%h want 0", nm, c, quot, rem);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; signed_div = 1'b0; dividend = 32'd9; divisor = 32'd3; annul = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (stallreq !== 1'b0 || ready !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs got s=%b r=%b q=%h rm=%h want 0", stallreq, ready, quot, rem);
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got s=%b r=%b want 0 0", stallreq, ready);
        end
    endtask

    task automatic test_unsigned();
        run_divide(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u_100_7");
        run_divide(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, "u_3_10");
        run_divide(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, "u_big_2");
        run_divide(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, "u_max_16");
    endtask

    task automatic test_signed();
        run_divide(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        run_divide(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "s_7_m2");
        run_divide(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "s_m7_m2");
        run_divide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "s_min_m1");
    endtask

    task automatic test_divzero();
        run_divide(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, "u_5_0");
        run_divide(1'b1, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, "s_m7_0");
    endtask

    task automatic test_back_to_back();
        run_divide(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "b2b_a");
        run_divide(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, "b2b_b");
        run_divide(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "b2b_c");
    endtask

    task automatic test_annul();
        // Annul while idle must beat start and not launch anything.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_div = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle_prio got s=%b r=%b want 0 0", stallreq, ready);
        end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle_nolaunch stallreq got %b want 0", stallreq);
        end
        // Annul mid-divide at cycle 10.
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            start = (c <= 10);
            annul = (c == 10);
            #1;
            checks++;
            if (stallreq !== ((c < 10) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL annul_mid stallreq cyc %0d got %b want %b", c, stallreq, (c < 10));
            end
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL annul_mid ready cyc %0d got %b want 0", c, ready);
            end
        end
        annul = 1'b0;
        run_divide(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, "after_annul");
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            start = (c <= 20);
            signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
            rst = (c == 20);
            #1;
            if (c >= 20) begin
                checks++;
                if (stallreq !== 1'b0 || ready !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
                    errors++;
                    $display("FAIL rst_mid cyc %0d got s=%b r=%b q=%h rm=%h want 0", c, stallreq, ready, quot, rem);
                end
            end else begin
                checks++;
                if (stallreq !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_pre stallreq cyc %0d got %b want 1", c, stallreq);
                end
            end
        end
        rst = 1'b0;
        run_divide(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "after_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; annul = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_back_to_back();
        test_annul();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
